// File: rtl/pwm_multi_if.sv
// Control bus for pwm_multi: run enable, prescaler, period and duty writes.
// The register side drives through master, the PWM core samples through slave.
interface pwm_multi_if #(
    parameter int CH    = 4,
    parameter int RES   = 8,
    parameter int PRE_W = 16
);
    logic              enable;
    logic [PRE_W-1:0]  prescale;
    logic [RES-1:0]    period;
    logic [CH*RES-1:0] duty;
    logic              wr;

    modport master (
        output enable, prescale, period, duty, wr
    );

    modport slave (
        input enable, prescale, period, duty, wr
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM, shared prescaled counter, shadowed duty/period.
// Define PWM_CENTER_ALIGN_EN for a triangle (centre-aligned) counter.
module pwm_multi #(
    parameter int CH    = 4,
    parameter int RES   = 8,
    parameter int PRE_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    pwm_multi_if.slave    bus,
    output logic [CH-1:0] out,
    output logic          period_start
);
    logic [PRE_W-1:0]  pre_cnt, pre_nxt;
    logic [RES-1:0]    cnt, cnt_nxt;
    logic [RES-1:0]    act_per, act_per_nxt, sh_per;
    logic [CH*RES-1:0] act_duty, act_duty_nxt, sh_duty;
    logic              pending, pend_nxt;
    logic              run, start, tick, wrap, load;
    logic [CH-1:0]     out_nxt;
`ifdef PWM_CENTER_ALIGN_EN
    logic              up, up_nxt, climb;
`endif

    always_comb begin
        // first enabled clk restarts a clean period without a wrap
        start   = bus.enable & ~run;
        tick    = bus.enable & run & (pre_cnt == bus.prescale);
        pre_nxt = pre_cnt + PRE_W'(1);
        if (!bus.enable || start || tick)
            pre_nxt = '0;
        cnt_nxt = cnt;
        wrap    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        up_nxt = up;
        climb  = up && (cnt != act_per);
        if (tick) begin
            unique case (1'b1)
                climb: cnt_nxt = cnt + RES'(1);
                (!climb && cnt <= RES'(1)): begin
                    cnt_nxt = '0;
                    up_nxt  = 1'b1;
                    wrap    = 1'b1;
                end
                (!climb && cnt > RES'(1)): begin
                    cnt_nxt = cnt - RES'(1);
                    up_nxt  = 1'b0;
                end
            endcase
        end
        if (!bus.enable || start)
            up_nxt = 1'b1;
`else
        if (tick) begin
            unique case (1'b1)
                (cnt == act_per): begin
                    cnt_nxt = '0;
                    wrap    = 1'b1;
                end
                (cnt != act_per): cnt_nxt = cnt + RES'(1);
            endcase
        end
`endif
        if (!bus.enable || start)
            cnt_nxt = '0;
        load         = wrap | start | ~bus.enable;
        act_per_nxt  = act_per;
        act_duty_nxt = act_duty;
        pend_nxt     = pending | bus.wr;
        if (load) begin
            pend_nxt = 1'b0;
            if (bus.wr) begin
                act_per_nxt  = bus.period;
                act_duty_nxt = bus.duty;
            end else if (pending) begin
                act_per_nxt  = sh_per;
                act_duty_nxt = sh_duty;
            end
        end
        for (int i = 0; i < CH; i++)
            out_nxt[i] = bus.enable &
                (cnt_nxt < act_duty_nxt[i*RES +: RES]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            act_per      <= '0;
            act_duty     <= '0;
            sh_per       <= '0;
            sh_duty      <= '0;
            pending      <= 1'b0;
            run          <= 1'b0;
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            pre_cnt  <= pre_nxt;
            cnt      <= cnt_nxt;
            act_per  <= act_per_nxt;
            act_duty <= act_duty_nxt;
            pending  <= pend_nxt;
            run      <= bus.enable;
            out      <= out_nxt;
            if (bus.wr) begin
                sh_per  <= bus.period;
                sh_duty <= bus.duty;
            end
`ifdef PWM_CENTER_ALIGN_EN
            period_start <= wrap | start;
`else
            period_start <= wrap;
`endif
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    always_ff @(posedge clk) begin
        if (reset)
            up <= 1'b1;
        else
            up <= up_nxt;
    end
`endif
endmodule
